// File: rtl/store_data_align_pkg.sv
// Shared types for the store path: memory access types, store FSM encoding
// and the access-size-to-byte-strobe helper.
package store_data_align_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      MEM_B  = 3'd0,
      MEM_H  = 3'd1,
      MEM_W  = 3'd2,
      MEM_BU = 3'd4,
      MEM_HU = 3'd5
   } mem_type;

   // Plain logic encoding so legacy code comparing raw state bits keeps working
   typedef logic [1:0] st_state_t;
   localparam st_state_t ST_IDLE  = 2'd0;
   localparam st_state_t ST_BEAT0 = 2'd1;
   localparam st_state_t ST_BEAT1 = 2'd2;
   localparam st_state_t ST_FLAG  = 2'd3;

   // Unsigned variants write the same bytes as their signed counterparts
   function automatic logic [3:0] size_strobe(mem_type t);
      case (t)
         MEM_H, MEM_HU: size_strobe = 4'b0011;
         MEM_W:         size_strobe = 4'b1111;
         default:       size_strobe = 4'b0001;
      endcase
   endfunction

endpackage

// File: rtl/store_data_align_if.sv
// Request and data-memory write channels of the store aligner. The slave
// modport is the aligner's view, master is the surrounding pipeline/memory.
interface store_data_align_if
   import store_data_align_pkg::*;
#(
   parameter int DATA_LENGTH = 32
);
   logic                   req_valid;
   logic                   req_ready;
   logic [DATA_LENGTH-1:0] req_addr;
   logic [DATA_LENGTH-1:0] req_data;
   mem_type                req_type;

   logic                   mem_valid;
   logic                   mem_ready;
   logic [DATA_LENGTH-1:0] mem_addr;
   logic [DATA_LENGTH-1:0] mem_wdata;
   logic [3:0]             mem_wstrb;

   modport slave (
      input  req_valid, req_addr, req_data, req_type, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output req_valid, req_addr, req_data, req_type, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/store_lane_align.sv
// Combinational lane placement: shifts size-masked store data and strobes
// onto a two-word window and reports whether the second word is touched.
module store_lane_align
   import store_data_align_pkg::*;
(
   input  logic [1:0]  off,
   input  mem_type     acc_type,
   input  logic [31:0] data,
   output logic [31:0] wdata0,
   output logic [3:0]  wstrb0,
   output logic [31:0] wdata1,
   output logic [3:0]  wstrb1,
   output logic        split
);

   logic [3:0]  strb;
   logic [31:0] mask;
   logic [63:0] wide_data;
   logic [7:0]  wide_strb;

   always_comb begin
      strb      = size_strobe(acc_type);
      mask      = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      wide_data = {32'd0, data & mask} << {off, 3'b000};
      wide_strb = {4'd0, strb} << off;
      wdata0    = wide_data[31:0];
      wdata1    = wide_data[63:32];
      wstrb0    = wide_strb[3:0];
      wstrb1    = wide_strb[7:4];
      split     = |wide_strb[7:4];
   end

endmodule

// File: rtl/store_data_align.sv
// Store aligner: captures a store request, then issues one or two word-aligned
// write beats to data memory over a valid/ready handshake.
module store_data_align
   import store_data_align_pkg::*;
#(
   parameter int DATA_LENGTH = 32,
   parameter bit ALLOW_SPLIT = 1'b1
)(
   input  logic                clk,
   input  logic                rst_n,
   store_data_align_if.slave   bus,
   output logic                st_done,
   output logic                st_misalign
);

   st_state_t              state;
   logic                   req_ready;
   logic                   req_fire;
   logic [31:0]            lane_wdata0;
   logic [31:0]            lane_wdata1;
   logic [3:0]             lane_wstrb0;
   logic [3:0]             lane_wstrb1;
   logic                   lane_split;
   logic [DATA_LENGTH-1:0] beat0_addr;

   logic                   mem_valid_q;
   logic [DATA_LENGTH-1:0] mem_addr_q;
   logic [DATA_LENGTH-1:0] mem_wdata_q;
   logic [3:0]             mem_wstrb_q;
   logic [DATA_LENGTH-1:0] addr1_q;
   logic [DATA_LENGTH-1:0] wdata1_q;
   logic [3:0]             wstrb1_q;
   logic                   split_q;

   store_lane_align u_lane (
      .off      (bus.req_addr[1:0]),
      .acc_type (bus.req_type),
      .data     (bus.req_data),
      .wdata0   (lane_wdata0),
      .wstrb0   (lane_wstrb0),
      .wdata1   (lane_wdata1),
      .wstrb1   (lane_wstrb1),
      .split    (lane_split)
   );

   assign req_ready  = (state == ST_IDLE);
   assign req_fire   = bus.req_valid & req_ready;
   assign beat0_addr = {bus.req_addr[DATA_LENGTH-1:2], 2'b00};

   assign bus.req_ready = req_ready;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;

   // Beat0 goes straight into the output registers; beat1 waits in a side buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         addr1_q     <= '0;
         wdata1_q    <= '0;
         wstrb1_q    <= '0;
         split_q     <= 1'b0;
         st_done     <= 1'b0;
         st_misalign <= 1'b0;
      end else begin
         st_done     <= 1'b0;
         st_misalign <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_fire) begin
                  addr1_q  <= beat0_addr + 32'd4;
                  wdata1_q <= lane_wdata1;
                  wstrb1_q <= lane_wstrb1;
                  split_q  <= lane_split;
                  if (lane_split && !ALLOW_SPLIT) begin
                     state       <= ST_FLAG;
                     st_misalign <= 1'b1;
                  end else begin
                     state       <= ST_BEAT0;
                     mem_valid_q <= 1'b1;
                     mem_addr_q  <= beat0_addr;
                     mem_wdata_q <= lane_wdata0;
                     mem_wstrb_q <= lane_wstrb0;
                  end
               end
            end
            ST_BEAT0: begin
               if (bus.mem_ready) begin
                  if (split_q) begin
                     state       <= ST_BEAT1;
                     mem_addr_q  <= addr1_q;
                     mem_wdata_q <= wdata1_q;
                     mem_wstrb_q <= wstrb1_q;
                  end else begin
                     state       <= ST_IDLE;
                     mem_valid_q <= 1'b0;
                     mem_addr_q  <= '0;
                     mem_wdata_q <= '0;
                     mem_wstrb_q <= '0;
                     st_done     <= 1'b1;
                  end
               end
            end
            ST_BEAT1: begin
               if (bus.mem_ready) begin
                  state       <= ST_IDLE;
                  mem_valid_q <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
                  st_done     <= 1'b1;
               end
            end
            ST_FLAG: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_store_data_align.sv
// Directed bench for store_data_align: one splitting instance and one
// instance that flags word-crossing stores instead of splitting them.
module tb_store_data_align;
   import store_data_align_pkg::*;

   logic clk;
   logic rst_n;
   logic st_done_a;
   logic st_misalign_a;
   logic st_done_b;
   logic st_misalign_b;
   int   checks = 0;
   int   errors = 0;

   store_data_align_if #(.DATA_LENGTH(32)) ba ();
   store_data_align_if #(.DATA_LENGTH(32)) bb ();

   store_data_align #(.DATA_LENGTH(32), .ALLOW_SPLIT(1'b1)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (ba.slave),
      .st_done     (st_done_a),
      .st_misalign (st_misalign_a)
   );

   store_data_align #(.DATA_LENGTH(32), .ALLOW_SPLIT(1'b0)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bb.slave),
      .st_done     (st_done_b),
      .st_misalign (st_misalign_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkBeatA(input string tag, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
      checkOutput({tag, ".valid"}, {31'd0, ba.mem_valid}, 32'd1);
      checkOutput({tag, ".addr"}, ba.mem_addr, addr);
      checkOutput({tag, ".wdata"}, ba.mem_wdata, wdata);
      checkOutput({tag, ".wstrb"}, {28'd0, ba.mem_wstrb}, {28'd0, wstrb});
   endtask

   // Called at a falling edge; the request is presented for exactly one rising edge
   task automatic applyStimulus(input bit use_b, input logic [31:0] addr,
                                input logic [31:0] data, input mem_type t);
      if (use_b) begin
         bb.req_valid = 1'b1;
         bb.req_addr  = addr;
         bb.req_data  = data;
         bb.req_type  = t;
      end else begin
         ba.req_valid = 1'b1;
         ba.req_addr  = addr;
         ba.req_data  = data;
         ba.req_type  = t;
      end
      @(posedge clk);
      #1;
      ba.req_valid = 1'b0;
      bb.req_valid = 1'b0;
      ba.req_data  = 32'hXXXX_XXXX;
      bb.req_data  = 32'hXXXX_XXXX;
   endtask

   initial begin
      rst_n        = 1'b0;
      ba.req_valid = 1'b0;
      ba.req_addr  = '0;
      ba.req_data  = '0;
      ba.req_type  = MEM_B;
      ba.mem_ready = 1'b1;
      bb.req_valid = 1'b0;
      bb.req_addr  = '0;
      bb.req_data  = '0;
      bb.req_type  = MEM_B;
      bb.mem_ready = 1'b1;

      // Reset state
      #12;
      checkOutput("rst.valid", {31'd0, ba.mem_valid}, 32'd0);
      checkOutput("rst.addr", ba.mem_addr, 32'd0);
      checkOutput("rst.wdata", ba.mem_wdata, 32'd0);
      checkOutput("rst.wstrb", {28'd0, ba.mem_wstrb}, 32'd0);
      checkOutput("rst.done", {31'd0, st_done_a}, 32'd0);
      checkOutput("rst.misalign", {31'd0, st_misalign_b}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst.ready_a", {31'd0, ba.req_ready}, 32'd1);
      checkOutput("rst.ready_b", {31'd0, bb.req_ready}, 32'd1);

      // SB at lane 2
      applyStimulus(1'b0, 32'h0000_1002, 32'hAABB_CCDD, MEM_B);
      @(negedge clk);
      checkBeatA("sb", 32'h0000_1000, 32'h00DD_0000, 4'b0100);
      checkOutput("sb.ready", {31'd0, ba.req_ready}, 32'd0);
      checkOutput("sb.done0", {31'd0, st_done_a}, 32'd0);
      @(negedge clk);
      checkOutput("sb.done1", {31'd0, st_done_a}, 32'd1);
      checkOutput("sb.valid_off", {31'd0, ba.mem_valid}, 32'd0);
      checkOutput("sb.ready_back", {31'd0, ba.req_ready}, 32'd1);
      @(negedge clk);
      checkOutput("sb.done2", {31'd0, st_done_a}, 32'd0);

      // SW at offset 3 splits
      applyStimulus(1'b0, 32'h0000_1003, 32'h1122_3344, MEM_W);
      @(negedge clk);
      checkBeatA("sw3.b0", 32'h0000_1000, 32'h4400_0000, 4'b1000);
      @(negedge clk);
      checkBeatA("sw3.b1", 32'h0000_1004, 32'h0011_2233, 4'b0111);
      checkOutput("sw3.done_mid", {31'd0, st_done_a}, 32'd0);
      @(negedge clk);
      checkOutput("sw3.done", {31'd0, st_done_a}, 32'd1);
      checkOutput("sw3.valid_off", {31'd0, ba.mem_valid}, 32'd0);
      @(negedge clk);
      checkOutput("sw3.done_once", {31'd0, st_done_a}, 32'd0);

      // SW crossing the top of the address space wraps
      applyStimulus(1'b0, 32'hFFFF_FFFE, 32'h1122_3344, MEM_W);
      @(negedge clk);
      checkBeatA("wrap.b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
      @(negedge clk);
      checkBeatA("wrap.b1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
      @(negedge clk);
      checkOutput("wrap.done", {31'd0, st_done_a}, 32'd1);

      // SH with memory back-pressure
      ba.mem_ready = 1'b0;
      applyStimulus(1'b0, 32'h0000_2000, 32'hFFFF_8001, MEM_H);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkBeatA("stall", 32'h0000_2000, 32'h0000_8001, 4'b0011);
         checkOutput("stall.ready", {31'd0, ba.req_ready}, 32'd0);
         checkOutput("stall.done", {31'd0, st_done_a}, 32'd0);
      end
      ba.mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall.done_end", {31'd0, st_done_a}, 32'd1);
      checkOutput("stall.valid_off", {31'd0, ba.mem_valid}, 32'd0);
      checkOutput("stall.ready_back", {31'd0, ba.req_ready}, 32'd1);

      // Unsigned types write like their signed counterparts
      applyStimulus(1'b0, 32'h0000_1001, 32'h0000_1234, MEM_BU);
      @(negedge clk);
      checkBeatA("sbu", 32'h0000_1000, 32'h0000_3400, 4'b0010);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0000_1002, 32'hABCD_1234, MEM_HU);
      @(negedge clk);
      checkBeatA("shu", 32'h0000_1000, 32'h1234_0000, 4'b1100);
      @(negedge clk);
      checkOutput("shu.done", {31'd0, st_done_a}, 32'd1);

      // Non-splitting instance: crossing SH is flagged, not issued
      applyStimulus(1'b1, 32'h0000_3003, 32'h0000_1234, MEM_H);
      @(negedge clk);
      checkOutput("flag.valid", {31'd0, bb.mem_valid}, 32'd0);
      checkOutput("flag.misalign", {31'd0, st_misalign_b}, 32'd1);
      checkOutput("flag.done", {31'd0, st_done_b}, 32'd0);
      checkOutput("flag.ready", {31'd0, bb.req_ready}, 32'd0);
      @(negedge clk);
      checkOutput("flag.misalign_off", {31'd0, st_misalign_b}, 32'd0);
      checkOutput("flag.ready_back", {31'd0, bb.req_ready}, 32'd1);
      checkOutput("flag.valid_off", {31'd0, bb.mem_valid}, 32'd0);
      checkOutput("flag.done_off", {31'd0, st_done_b}, 32'd0);

      // Non-splitting instance still issues aligned stores
      applyStimulus(1'b1, 32'h0000_3000, 32'hCAFE_F00D, MEM_W);
      @(negedge clk);
      checkOutput("b_sw.valid", {31'd0, bb.mem_valid}, 32'd1);
      checkOutput("b_sw.addr", bb.mem_addr, 32'h0000_3000);
      checkOutput("b_sw.wdata", bb.mem_wdata, 32'hCAFE_F00D);
      checkOutput("b_sw.wstrb", {28'd0, bb.mem_wstrb}, 32'h0000_000F);
      checkOutput("b_sw.misalign", {31'd0, st_misalign_b}, 32'd0);
      @(negedge clk);
      checkOutput("b_sw.done", {31'd0, st_done_b}, 32'd1);

      // Reset during beat1 abandons the store
      applyStimulus(1'b0, 32'h0000_1001, 32'hDEAD_BEEF, MEM_W);
      @(negedge clk);
      checkBeatA("abort.b0", 32'h0000_1000, 32'hADBE_EF00, 4'b1110);
      @(negedge clk);
      checkBeatA("abort.b1", 32'h0000_1004, 32'h0000_00DE, 4'b0001);
      rst_n = 1'b0;
      #1;
      checkOutput("abort.valid_async", {31'd0, ba.mem_valid}, 32'd0);
      checkOutput("abort.wstrb", {28'd0, ba.mem_wstrb}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort.done_rst", {31'd0, st_done_a}, 32'd0);
      @(negedge clk);
      checkOutput("abort.ready", {31'd0, ba.req_ready}, 32'd1);
      checkOutput("abort.valid", {31'd0, ba.mem_valid}, 32'd0);
      checkOutput("abort.done", {31'd0, st_done_a}, 32'd0);
      applyStimulus(1'b0, 32'h0000_4000, 32'h0000_0055, MEM_B);
      @(negedge clk);
      checkBeatA("after", 32'h0000_4000, 32'h0000_0055, 4'b0001);
      @(negedge clk);
      checkOutput("after.done", {31'd0, st_done_a}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_data_align.md
Name: store_data_align

Overview:
- Write-side counterpart of the load-data extender.
- Accepts a store request (byte address, register data, access type), positions the data on 32-bit word lanes and generates byte strobes.
- Issues the write to data memory over a valid/ready handshake, splitting word-crossing misaligned stores into two word-aligned beats.
- Sits between the execute/MEM stage and the data-memory port.

Parameters:
- DATA_LENGTH, 32, data/address width (block supports 32 only).
- ALLOW_SPLIT, 1, 1 = split word-crossing stores into two beats; 0 = flag them via st_misalign and issue no bus traffic.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  DATA_LENGTH  byte address.
- req_data  in  DATA_LENGTH  store data, right-justified.
- req_type  in  mem_type  B/H/W; BU treated as B, HU treated as H.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  DATA_LENGTH  word-aligned address (bits[1:0] = 0).
- mem_wdata  out  DATA_LENGTH  lane-aligned data; unused lanes 0.
- mem_wstrb  out  4  byte strobes, bit i = byte lane i.
- st_done  out  1  one-cycle pulse after the final beat handshakes.
- st_misalign  out  1  one-cycle pulse for a rejected crossing store (ALLOW_SPLIT=0 only).

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_valid, st_done and st_misalign = 0; mem_addr, mem_wdata and mem_wstrb = 0; req_ready = 1 once released. Reset mid-transaction drops mem_valid immediately and abandons the request, with no st_done.
- Size strobe: B = 0001, H = 0011, W = 1111. Data is masked to the access size.
- Lane alignment: off = req_addr[1:0].
  - 64-bit wide data = masked_data << (8*off).
  - 8-bit wide strobe = size_strobe << off.
  - Beat0 uses the low half of each; beat1 uses the high half.
  - A split is needed when the high strobe nibble is nonzero: H at off 3, or W at off 1-3.
- Beat addresses: beat0 = {req_addr[31:2],2'b00}; beat1 = beat0 + 4, mod 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Request capture: all request fields and computed beats are registered on the req_valid & req_ready handshake. req_* are don't-care afterwards.
- FSM states: IDLE, BEAT0, BEAT1, FLAG.
  - IDLE: req_ready = 1. On handshake go to BEAT0 if no split is needed or ALLOW_SPLIT=1; go to FLAG if a split is needed and ALLOW_SPLIT=0.
  - BEAT0: mem_valid = 1 with beat0 fields. On mem_ready, go to BEAT1 if split, else to IDLE with st_done pulsed in the next cycle.
  - BEAT1: mem_valid = 1 with beat1 fields. On mem_ready, go to IDLE with st_done pulsed in the next cycle.
  - FLAG: st_misalign = 1 for one cycle, then IDLE. No mem_valid, no st_done.
- Outputs are registered. Latency is handshake to mem_valid = 1 cycle. Throughput is at most one request per 2 cycles (unsplit, mem_ready tied high).
- Handshake rules:
  - While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_wstrb hold stable.
  - mem_valid never deasserts without a handshake, except on reset.
  - mem_ready while mem_valid=0 is ignored.
- Unused wdata lanes are driven to 0. mem_wstrb is never 0 while mem_valid=1.

Decomposition:
- RVS192_package: reuse mem_type. Add st_state_t (IDLE, BEAT0, BEAT1, FLAG) and a size_strobe function (mem_type -> 4-bit).
- Sub-module store_lane_align: purely combinational.
  - Inputs: off, type, data.
  - Outputs: wdata0, wstrb0, wdata1, wstrb1, split.
  - Instantiated once, ahead of the capture registers.

Test Plan:
- SB addr 0x1002 data 0xAABBCCDD, mem_ready=1 -> one beat: mem_addr 0x1000, wdata 0x00DD0000, wstrb 0100; st_done 1 cycle after handshake.
- SW addr 0x1003 data 0x11223344 -> beat0 0x1000/0x44000000/1000, then beat1 0x1004/0x00112233/0111; single st_done.
- SW addr 0xFFFFFFFE data 0x11223344 -> beat0 0xFFFFFFFC/0x33440000/1100, beat1 0x00000000/0x00001122/0011.
- SH addr 0x2000 data 0xFFFF8001, mem_ready low 3 cycles -> mem outputs stable (0x2000/0x00008001/0011) throughout; req_ready=0 until return to IDLE.
- ALLOW_SPLIT=0, SH addr 0x3003 -> no mem_valid, st_misalign pulses 1 cycle, no st_done, req_ready back high next cycle.
- SW split, rst_n low during BEAT1 -> mem_valid drops asynchronously; after release state is IDLE, no st_done, next SB at 0x4000 completes normally.
